// File: rtl/aww_types_pkg.sv
// Arbiter-local types: FSM states, the latched request record and the error fill word.
package aww_types_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IREQ,
    ARB_DREQ,
    ARB_RESP
  } arb_state_t;

  typedef struct packed {
    cpu_types_pkg::word_t addr;
    cpu_types_pkg::word_t store;
    logic                 wen;
    logic                 is_d;
  } arb_req_t;

  localparam cpu_types_pkg::word_t ARB_ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: the 32-bit machine word and the RAM handshake status.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/arb_retry_ctr.sv
// Counts RAM re-issues for the access in flight; exhausted once MAX_RETRY re-issues were spent.
module arb_retry_ctr #(
  parameter int MAX_RETRY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic exhausted
);

  localparam int W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !exhausted) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign exhausted = (cnt == W'(MAX_RETRY));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data requests onto one RAM port and pulses ihit/dhit on completion.
// Minimum request-to-hit is 2 cycles; requesters hold their request until their hit.
module mem_arbiter
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
#(
  parameter int MAX_RETRY = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        mem_err
);

  arb_state_t state, state_next;
  arb_req_t   lat, grant_req;
  ramstate_t  rs;
  word_t      load_val;
  logic       last_d, reissue, reissue_next;
  logic       grant, grant_d, ctr_inc, access_done, err_done, done;
  logic       exhausted, driving, dreq;

  assign rs       = ramstate_t'(ramstate);
  assign dreq     = dREN | dWEN;
  assign done     = access_done | err_done;
  assign load_val = err_done ? ARB_ERR_WORD : ramload;

  arb_retry_ctr #(
    .MAX_RETRY(MAX_RETRY)
  ) u_retry (
    .clk      (CLK),
    .rst      (RST),
    .clr      (grant),
    .inc      (ctr_inc),
    .exhausted(exhausted)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    grant        = 1'b0;
    grant_d      = 1'b0;
    ctr_inc      = 1'b0;
    access_done  = 1'b0;
    err_done     = 1'b0;
    reissue_next = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (dreq || iREN) begin
          grant      = 1'b1;
          // Data wins a tie unless it also won the previous grant.
          grant_d    = dreq & ~(iREN & last_d);
          state_next = grant_d ? ARB_DREQ : ARB_IREQ;
        end
      end
      ARB_IREQ, ARB_DREQ: begin
        // The RAM status is meaningless while the enables are dropped for a re-issue.
        if (!reissue) begin
          if (rs == ACCESS) begin
            access_done = 1'b1;
            state_next  = ARB_RESP;
          end else if (rs == ERROR) begin
            if (exhausted) begin
              err_done   = 1'b1;
              state_next = ARB_RESP;
            end else begin
              ctr_inc      = 1'b1;
              reissue_next = 1'b1;
            end
          end
        end
      end
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_req       = '0;
    grant_req.addr  = grant_d ? daddr : iaddr;
    grant_req.store = dstore;
    grant_req.wen   = grant_d & dWEN;
    grant_req.is_d  = grant_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lat     <= '0;
      last_d  <= 1'b0;
      reissue <= 1'b0;
      ihit    <= 1'b0;
      dhit    <= 1'b0;
      mem_err <= 1'b0;
      iload   <= '0;
      dload   <= '0;
    end else begin
      reissue <= reissue_next;
      ihit    <= done & ~lat.is_d;
      dhit    <= done & lat.is_d;
      mem_err <= err_done;
      if (grant) begin
        lat    <= grant_req;
        last_d <= grant_d;
      end
      if (done && !lat.wen) begin
        if (lat.is_d) begin
          dload <= load_val;
        end else begin
          iload <= load_val;
        end
      end
    end
  end

  // RAM side is decoded from registered state only, never from the live request inputs.
  assign driving  = ((state == ARB_IREQ) || (state == ARB_DREQ)) && !reissue;
  assign ramREN   = driving & ~lat.wen;
  assign ramWEN   = driving & lat.wen;
  assign ramaddr  = driving ? lat.addr : '0;
  assign ramstore = (driving && lat.wen) ? lat.store : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table-driven single accesses, arbitration/reset sequences, random traffic vs. a transaction model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  import aww_types_pkg::*;

  localparam int MAXR   = 3;
  localparam int P_NONE = 0;
  localparam int P_DRIVE = 1;
  localparam int P_GAP  = 2;
  localparam int P_HIT  = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [1:0]  ramstate = 2'd0;
  logic [31:0] ramload = '0;
  logic        ramREN, ramWEN, ihit, dhit, mem_err;
  logic [31:0] ramaddr, ramstore, iload, dload;

  mem_arbiter #(.MAX_RETRY(MAXR)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic wen; logic [31:0] addr; logic [31:0] store; } req_t;
  typedef struct { int wait_n; int nerr; logic [31:0] load; } rsp_t;
  typedef struct {
    bit          is_d;
    req_t        rq;
    rsp_t        rs;
    logic [31:0] exp_load;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  req_t  iq[$];
  req_t  dq[$];
  rsp_t  rq[$];
  bit    i_up = 0, d_up = 0, rnd = 0, rst_hold = 1;
  // Transaction-level reference state
  int    phase = P_NONE;
  bit    m_idle = 0, idle_pend = 0, m_last_d = 0;
  bit    cur_d = 0, cur_err = 0;
  req_t  cur;
  rsp_t  cur_rsp;
  int    busy_left = 0, errs_seen = 0, grant_cyc = 0;
  logic [31:0] m_iload = '0, m_dload = '0;
  // Observations of the most recent hit
  int    last_lat = 0;
  logic [31:0] last_load = '0;
  logic  last_err = 1'b0;
  string hits = "";
  vec_t  tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic model_reset();
    phase = P_NONE; m_idle = 0; idle_pend = 0; m_last_d = 0;
    m_iload = '0; m_dload = '0;
  endtask

  // One clock: compare outputs against the model, then play RAM and requesters for the next edge.
  task automatic tick();
    int ph;
    bit gd;
    @(posedge CLK);
    #1;
    cyc++;
    ph = phase;
    if (ph == P_HIT && !cur.wen) begin
      if (cur_d) m_dload = cur_err ? ARB_ERR_WORD : cur_rsp.load;
      else       m_iload = cur_err ? ARB_ERR_WORD : cur_rsp.load;
    end
    chk("ramREN", ramREN, ph == P_DRIVE && !cur.wen);
    chk("ramWEN", ramWEN, ph == P_DRIVE && cur.wen);
    if (ph == P_DRIVE) begin
      chk("ramaddr", ramaddr, cur.addr);
      if (cur.wen) chk("ramstore", ramstore, cur.store);
    end
    chk("ihit", ihit, ph == P_HIT && !cur_d);
    chk("dhit", dhit, ph == P_HIT && cur_d);
    chk("mem_err", mem_err, ph == P_HIT && cur_err);
    chk("iload", iload, m_iload);
    chk("dload", dload, m_dload);
    if (ihit) hits = {hits, "i"};
    if (dhit) hits = {hits, "d"};

    ramstate = FREE;
    ramload  = $urandom;
    case (ph)
      P_HIT: begin
        last_lat  = cyc - grant_cyc;
        last_load = cur_d ? dload : iload;
        last_err  = mem_err;
        if (cur_d) begin void'(dq.pop_front()); d_up = 0; end
        else       begin void'(iq.pop_front()); i_up = 0; end
        phase = P_NONE;
        idle_pend = 1;
      end
      P_GAP: phase = P_DRIVE;
      P_DRIVE: begin
        if (busy_left > 0) begin
          ramstate = BUSY;
          busy_left--;
        end else if (errs_seen < cur_rsp.nerr) begin
          ramstate = ERROR;
          errs_seen++;
          if (errs_seen > MAXR) begin cur_err = 1; phase = P_HIT; end
          else begin phase = P_GAP; busy_left = cur_rsp.wait_n; end
        end else begin
          ramstate = ACCESS;
          ramload  = cur_rsp.load;
          phase    = P_HIT;
        end
      end
      default: if (idle_pend) begin m_idle = 1; idle_pend = 0; end
    endcase

    if (!i_up && iq.size() > 0 && (!rnd || $urandom_range(1, 0) == 1)) i_up = 1;
    if (!d_up && dq.size() > 0 && (!rnd || $urandom_range(1, 0) == 1)) d_up = 1;
    iREN = i_up;
    dREN = 1'b0;
    dWEN = 1'b0;
    if (i_up) iaddr = iq[0].addr;
    if (d_up) begin
      dWEN   = dq[0].wen;
      dREN   = !dq[0].wen || (rnd && $urandom_range(1, 0) == 1);
      daddr  = dq[0].addr;
      dstore = dq[0].store;
    end
    // Inputs moving under a granted access must not matter.
    if (rnd && phase != P_NONE) begin
      if (cur_d) begin daddr = $urandom; dstore = $urandom; end
      else iaddr = $urandom;
    end

    if (rst_hold) begin
      RST = 1'b1;
      model_reset();
      ramstate = BUSY;
    end else begin
      if (RST) begin RST = 1'b0; m_idle = 1; end
      if (m_idle && (i_up || d_up)) begin
        gd = d_up && !(i_up && m_last_d);
        m_last_d = gd;
        cur_d = gd;
        if (gd) cur = dq[0];
        else    cur = iq[0];
        if (rq.size() > 0) cur_rsp = rq.pop_front();
        else cur_rsp = '{int'($urandom_range(2, 0)), int'($urandom_range(4, 0)), $urandom};
        busy_left = cur_rsp.wait_n;
        errs_seen = 0;
        cur_err   = 0;
        phase     = P_DRIVE;
        m_idle    = 0;
        grant_cyc = cyc;
      end
    end
  endtask

  task automatic run(input bit r, input int budget);
    int n;
    n = 0;
    rnd = r;
    while ((iq.size() > 0 || dq.size() > 0 || phase != P_NONE) && n < budget) begin
      tick();
      n++;
    end
    chk("pending_at_end", iq.size() + dq.size() + ((phase != P_NONE) ? 1 : 0), 0);
  endtask

  task automatic do_reset();
    rst_hold = 1;
    tick();
    tick();
    rst_hold = 0;
  endtask

  initial begin
    tbl[0] = '{0, '{0, 32'h40,  32'h0},        '{1, 0, 32'h8C220004}, 32'h8C220004, 0, 3};
    tbl[1] = '{1, '{1, 32'h100, 32'hDEADBEEF}, '{0, 0, 32'h0},        32'h0,        0, 2};
    tbl[2] = '{1, '{0, 32'h200, 32'h0},        '{0, 2, 32'h12345678}, 32'h12345678, 0, 6};
    tbl[3] = '{1, '{0, 32'h204, 32'h0},        '{0, 4, 32'h55555555}, 32'hBAD1BAD1, 1, 8};
    tbl[4] = '{0, '{0, 32'h44,  32'h0},        '{2, 1, 32'h0F0F0F0F}, 32'h0F0F0F0F, 0, 8};
    tbl[5] = '{1, '{0, 32'h208, 32'h0},        '{3, 0, 32'hA5A5A5A5}, 32'hA5A5A5A5, 0, 5};
    tbl[6] = '{0, '{0, 32'h48,  32'h0},        '{1, 4, 32'h11111111}, 32'hBAD1BAD1, 1, 12};
    tbl[7] = '{1, '{1, 32'h20C, 32'hCAFEF00D}, '{0, 1, 32'h0},        32'h0,        0, 4};

    do_reset();
    chk("reset_ramREN", ramREN, 0);
    chk("reset_iload", iload, 0);

    for (int k = 0; k < 8; k++) begin
      hits = "";
      if (tbl[k].is_d) dq.push_back(tbl[k].rq);
      else             iq.push_back(tbl[k].rq);
      rq.push_back(tbl[k].rs);
      run(0, 100);
      chk($sformatf("vec%0d_lat", k), last_lat, tbl[k].exp_lat);
      chk($sformatf("vec%0d_err", k), last_err, tbl[k].exp_err);
      chk_s($sformatf("vec%0d_port", k), hits, tbl[k].is_d ? "d" : "i");
      if (!tbl[k].rq.wen) chk($sformatf("vec%0d_load", k), last_load, tbl[k].exp_load);
    end

    // Simultaneous fetch and write after reset: the write goes first.
    do_reset();
    hits = "";
    iq.push_back('{0, 32'h40, 32'h0});
    dq.push_back('{1, 32'h100, 32'hDEADBEEF});
    rq.push_back('{0, 0, 32'h0});
    rq.push_back('{0, 0, 32'h8C220004});
    run(0, 100);
    chk_s("simul_order", hits, "di");
    chk("simul_iload", iload, 32'h8C220004);

    // Two data reads with the fetch held throughout alternate with it.
    do_reset();
    hits = "";
    iq.push_back('{0, 32'h80, 32'h0});
    dq.push_back('{0, 32'h300, 32'h0});
    dq.push_back('{0, 32'h304, 32'h0});
    rq.push_back('{0, 0, 32'h00000300});
    rq.push_back('{1, 0, 32'h00000080});
    rq.push_back('{0, 0, 32'h00000304});
    run(0, 100);
    chk_s("starve_order", hits, "did");

    // Reset while a data read is stalled on BUSY, then the held request is served afresh.
    do_reset();
    hits = "";
    dq.push_back('{0, 32'h400, 32'h0});
    rq.push_back('{10, 0, 32'h66666666});
    rq.push_back('{0, 0, 32'h77777777});
    for (int k = 0; k < 20 && !(phase == P_DRIVE && busy_left < 9); k++) tick();
    chk("pre_rst_ramREN", ramREN, 1);
    rst_hold = 1;
    tick();
    tick();
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    rst_hold = 0;
    run(0, 100);
    chk_s("rst_regrant", hits, "d");
    chk("rst_dload", dload, 32'h77777777);

    // Random mixed traffic against the model.
    do_reset();
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(1, 0) == 1)
        dq.push_back('{logic'($urandom_range(1, 0)), $urandom & 32'hFFFFFFFC, $urandom});
      else
        iq.push_back('{1'b0, $urandom & 32'hFFFFFFFC, 32'h0});
    end
    run(1, 20000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the pipeline's instruction-fetch port and data port. It serialises requests onto one RAM interface. It also generates the one-cycle `ihit`/`dhit` completion pulses that the hazard unit consumes for its stall and advance decisions. It sits between the datapath/cache request ports and the RAM model.

## Interface
Parameters:
- `MAX_RETRY`, default 3: number of re-issues after a `ramstate == ERROR` before the access completes with an error.

Ports (clock and reset first):
- `CLK`  in  1  system clock.
- `RST`  in  1  reset, synchronous, active-high.
- `iREN`  in  1  instruction read request; held until `ihit`.
- `iaddr`  in  32  instruction word address (`word_t`).
- `dREN`  in  1  data read request; held until `dhit`.
- `dWEN`  in  1  data write request; held until `dhit`. Mutually exclusive with `dREN`.
- `daddr`  in  32  data address.
- `dstore`  in  32  write data.
- `ramstate`  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR.
- `ramload`  in  32  RAM read data, valid when `ramstate == ACCESS`.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ihit`  out  1  one-cycle instruction completion pulse.
- `dhit`  out  1  one-cycle data completion pulse.
- `iload`  out  32  fetched instruction, valid with `ihit`, held afterwards.
- `dload`  out  32  loaded data, valid with `dhit`, held afterwards.
- `mem_err`  out  1  one-cycle pulse coinciding with the hit of an access that exhausted its retries.

## Operation
- FSM states `ARB_IDLE`, `ARB_IREQ`, `ARB_DREQ`, `ARB_RESP`.
- **`ARB_IDLE` grant rule:**
  - If data (`dREN|dWEN`) and instruction requests are both pending, grant data, unless the previous grant was data. In that case grant instruction (anti-starvation toggle `last_d`).
  - A sole request is granted directly.
  - On grant, latch the address, op, store data, and the grant type, and clear the retry counter.
- **`ARB_IREQ` / `ARB_DREQ`:**
  - Drive `ramaddr`/`ramstore` from the latched registers.
  - Assert `ramREN` (instruction or data read) or `ramWEN` (data write).
  - `ramstate == ACCESS`: capture `ramload` into `iload`/`dload` (reads only) and go to `ARB_RESP`.
  - `ramstate == ERROR` with retry count < `MAX_RETRY`: deassert the RAM enables for one cycle (internal `reissue` flag), increment the counter, then re-drive.
  - `ramstate == ERROR` with count == `MAX_RETRY`: go to `ARB_RESP` with the error flag set. Load data in that case is `32'hBAD1BAD1`.
  - FREE or BUSY: hold state.
- **`ARB_RESP`:**
  - Pulse the `ihit` or `dhit` that matches the latched grant. Pulse `mem_err` if flagged.
  - RAM enables are low, and requests are not sampled this cycle, so a still-asserted requester is not re-served.
  - Next state is always `ARB_IDLE`.
- Requests that drop before grant are ignored. Requests that change while granted have no effect, because the latched values are used.
- `dREN` and `dWEN` together is illegal; treat it as a write.

## Timing
- Reset values: state `ARB_IDLE`, `last_d = 0`, all outputs 0, `iload`/`dload` = 0, retry count 0.
- Reset mid-access aborts immediately. RAM enables are low in the cycle after `RST` is sampled.
- Latency:
  - Request seen in IDLE at cycle 0.
  - RAM enables high from cycle 1.
  - ACCESS sampled at cycle k gives the hit at cycle k+1.
  - Back in IDLE at k+2.
  - Minimum request-to-hit is 2 cycles (ACCESS at cycle 1).
- Each hit is exactly one cycle wide, and at most one of `ihit`/`dhit` is high per cycle.
- The earliest back-to-back grant to a waiting port is in the IDLE cycle after RESP.
- All outputs are registered, except `ramREN`/`ramWEN`/`ramaddr`/`ramstore`, which are decoded from registered state and latches (no request-to-RAM combinational path).

## Structure
- `arb_state_t` enum and the `ARB_ERR_WORD` constant go in `aww_types_pkg`.
- `word_t` and `ramstate_t` come from `cpu_types_pkg`.
- A natural sub-module is `arb_retry_ctr`: a retry counter sized `$clog2(MAX_RETRY+1)`, with clear and increment, exposing `exhausted`.

## Test plan
- **Instruction only:** `iREN=1`, `iaddr=0x40`, RAM returns ACCESS with `ramload=0x8C220004` on the 2nd driven cycle → `ramREN=1`, `ramaddr=0x40`; one-cycle `ihit` with `iload=0x8C220004`; no `dhit`.
- **Simultaneous requests:** `iREN` and `dWEN` (`daddr=0x100`, `dstore=0xDEADBEEF`) asserted together, `last_d=0` → the write completes first (`ramWEN`, `ramstore=0xDEADBEEF`, `dhit`), then the instruction fetch (`ihit`).
- **Anti-starvation:** two data reads back-to-back with `iREN` held throughout → order of hits is `dhit`, `ihit`, `dhit`.
- **Error retry:** ERROR returned twice then ACCESS with `MAX_RETRY=3` → RAM enables low for one cycle after each ERROR; `dhit` with correct data; `mem_err=0`.
- **Error exhaustion:** ERROR returned 4 times → `dhit` and `mem_err` pulse together; `dload=0xBAD1BAD1`.
- **Reset mid-access:** `RST` asserted while in `ARB_DREQ` with `ramstate=BUSY` → next cycle all outputs 0 and state IDLE; after `RST` deasserts, a held request is re-granted cleanly.
